// File: rtl/weight_kernel_loader_pkg.sv
// Shared definitions for the 5x5 convolution weight path: kernel geometry,
// default bus widths, loader state encoding and the read-tag format.
package weight_kernel_loader_pkg;

  localparam int unsigned KERNEL_DIM      = 5;
  localparam int unsigned KERNEL_TAPS     = KERNEL_DIM * KERNEL_DIM;
  localparam int unsigned CONV_DATA_WIDTH = 16;
  localparam int unsigned CONV_ADDR_WIDTH = 12;
  localparam int unsigned TAP_IDX_WIDTH   = 5;

  typedef logic [TAP_IDX_WIDTH-1:0] tap_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } loader_state_e;

  // Travels alongside each ROM read so the returning word lands on the right tap.
  typedef struct packed {
    logic     valid;
    tap_idx_t idx;
  } rd_tag_t;

endpackage

// File: rtl/weight_kernel_loader_rom_read_pipe.sv
// Delay line matching the ROM read latency; carries {valid, tap index} so
// each tag emerges on the same cycle as the ROM data it describes.
module rom_read_pipe
  import weight_kernel_loader_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [LATENCY];

  // Shift tags one stage per cycle; reset drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/weight_kernel_loader.sv
// Reads one 25-word kernel from the weight ROM starting at kernel_idx*25,
// assembles it into a flat tap bank and holds it stable for the conv engine.
module weight_kernel_loader
  import weight_kernel_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = CONV_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = CONV_ADDR_WIDTH,
  parameter int unsigned MEM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int unsigned KIDX_WIDTH  = 8,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [KIDX_WIDTH-1:0]             kernel_idx,
  output logic                              rom_ena,
  output logic [ADDR_WIDTH-1:0]             rom_addr,
  input  logic [DATA_WIDTH-1:0]             rom_dout,
  output logic [KERNEL_TAPS*DATA_WIDTH-1:0] weights_flat,
  output logic                              weights_valid,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  // Wide enough for kernel_idx*25+24 and for MEM_DEPTH-1, so the range check never truncates.
  localparam int unsigned BW = (KIDX_WIDTH + 6 > ADDR_WIDTH + 1) ? KIDX_WIDTH + 6 : ADDR_WIDTH + 1;
  localparam logic [BW-1:0] LAST_ADDR = BW'(MEM_DEPTH - 1);
  localparam logic [BW-1:0] TAP_SPAN  = BW'(KERNEL_TAPS - 1);
  localparam logic [BW-1:0] TAPS_BW   = BW'(KERNEL_TAPS);
  localparam tap_idx_t      LAST_TAP  = tap_idx_t'(KERNEL_TAPS - 1);

  loader_state_e                     state_q, state_d;
  logic                              ena_q, ena_d;
  logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
  tap_idx_t                          cnt_q, cnt_d;
  logic [KERNEL_TAPS*DATA_WIDTH-1:0] bank_q, bank_d;
  logic                              valid_q, valid_d;
  logic                              done_q, done_d;
  logic                              err_q, err_d;

  logic [BW-1:0] base;
  logic [BW-1:0] last;
  logic          in_range;
  rd_tag_t       issue_tag;
  rd_tag_t       cap_tag;

  assign base     = BW'(kernel_idx) * TAPS_BW;
  assign last     = base + TAP_SPAN;
  assign in_range = (last <= LAST_ADDR);

  assign issue_tag = '{valid: ena_q, idx: cnt_q};

  rom_read_pipe #(
    .LATENCY(ROM_LATENCY)
  ) u_rd_pipe (
    .clk  (clk),
    .rst  (rst),
    .tag_i(issue_tag),
    .tag_o(cap_tag)
  );

  // Next-state, address sequencing, tap capture and completion pulses.
  always_comb begin
    state_d = state_q;
    ena_d   = ena_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (cap_tag.valid) begin
      bank_d[cap_tag.idx*DATA_WIDTH +: DATA_WIDTH] = rom_dout;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (in_range) begin
            state_d = ST_ISSUE;
            ena_d   = 1'b1;
            addr_d  = base[ADDR_WIDTH-1:0];
            cnt_d   = '0;
            valid_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (cnt_q == LAST_TAP) begin
          state_d = ST_DRAIN;
          ena_d   = 1'b0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cap_tag.valid && (cap_tag.idx == LAST_TAP)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ena_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      bank_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ena_q   <= ena_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rom_ena       = ena_q;
  assign rom_addr      = addr_q;
  assign weights_flat  = bank_q;
  assign weights_valid = valid_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_weight_kernel_loader.sv
// Scoreboard bench for weight_kernel_loader against ROM models with mem[i]=i,
// one instance at ROM latency 1 and one at latency 2.
module tb_weight_kernel_loader;
  import weight_kernel_loader_pkg::*;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int KW = 8;
  localparam int FW = KERNEL_TAPS * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, start2;
  logic [KW-1:0] kidx, kidx2;

  logic          rom_ena, rom_ena2;
  logic [AW-1:0] rom_addr, rom_addr2;
  logic [DW-1:0] rom_dout, rom_dout2;
  logic [FW-1:0] weights_flat, weights_flat2;
  logic          weights_valid, weights_valid2;
  logic          busy, busy2, done, done2, err, err2;

  weight_kernel_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(4096), .KIDX_WIDTH(KW), .ROM_LATENCY(1)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .kernel_idx(kidx),
    .rom_ena(rom_ena), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .weights_flat(weights_flat), .weights_valid(weights_valid),
    .busy(busy), .done(done), .err(err)
  );

  weight_kernel_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(4096), .KIDX_WIDTH(KW), .ROM_LATENCY(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .kernel_idx(kidx2),
    .rom_ena(rom_ena2), .rom_addr(rom_addr2), .rom_dout(rom_dout2),
    .weights_flat(weights_flat2), .weights_valid(weights_valid2),
    .busy(busy2), .done(done2), .err(err2)
  );

  // ROM models: contents equal to address
  logic [DW-1:0] r1_q, r2a_q, r2b_q;
  always @(posedge clk) if (rom_ena) r1_q <= DW'(rom_addr);
  always @(posedge clk) begin
    if (rom_ena2) r2a_q <= DW'(rom_addr2);
    r2b_q <= r2a_q;
  end
  assign rom_dout  = r1_q;
  assign rom_dout2 = r2b_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int base;
    int start_edge;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   addr_q[$];
  int   err_q[$];
  int   last_base = -1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_bank(input string nm, input logic [FW-1:0] f, input int base);
    int bad;
    logic [DW-1:0] want;
    bad = -1;
    for (int k = 0; k < KERNEL_TAPS; k++) begin
      want = DW'(base + k);
      if (bad < 0 && f[k*DW +: DW] !== want) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      want = DW'(base + bad);
      $display("FAIL %s: tap %0d got %0d expected %0d", nm, bad, f[bad*DW +: DW], want);
    end
  endtask

  // Monitor for the latency-1 instance
  always @(negedge clk) begin : mon1
    exp_t e;
    int   b;
    if (rom_ena && addr_q.size() > 0) begin
      check("rom_addr", int'(rom_addr), addr_q.pop_front());
    end
    if (done) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = q1.pop_front();
        check("done_latency", cyc - e.start_edge, 26);
        check_bank("bank", weights_flat, e.base);
        check("valid_at_done", int'(weights_valid), 1);
        check("busy_at_done", int'(busy), 0);
        check("ena_at_done", int'(rom_ena), 0);
        last_base = e.base;
      end
    end
    if (err) begin
      if (err_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_err: got err=1 expected 0 at cycle %0d", cyc);
      end else begin
        b = err_q.pop_front();
        check("busy_at_err", int'(busy), 0);
        check("valid_kept_at_err", int'(weights_valid), 1);
        check_bank("bank_kept_at_err", weights_flat, last_base);
      end
    end
  end

  // Monitor for the latency-2 instance
  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done2: got done2=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = q2.pop_front();
        check("done_latency_lat2", cyc - e.start_edge, 27);
        check_bank("bank_lat2", weights_flat2, e.base);
        check("valid_at_done_lat2", int'(weights_valid2), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: no expectation, 1: accepted load, 2: rejected (err)
  task automatic issue(input int k, input int mode);
    start = 1'b1;
    kidx  = KW'(k);
    if (mode == 1) begin
      q1.push_back('{base: k * 25, start_edge: cyc + 1});
      for (int i = 0; i < KERNEL_TAPS; i++) addr_q.push_back(k * 25 + i);
    end else if (mode == 2) begin
      err_q.push_back(k);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    int n;
    n = 0;
    while (!done && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: got no done within %0d cycles expected done", nm, lim);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; kidx = '0; kidx2 = '0;
    repeat (3) tick();
    check("rst_rom_ena", int'(rom_ena), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_flat_zero", int'(weights_flat != '0), 0);
    check("rst_valid", int'(weights_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done_err", int'({done, err}), 0);
    rst = 1'b0;
    tick();

    issue(0, 1);
    check("busy_after_start", int'(busy), 1);
    wait_done("done_k0", 60);

    issue(92, 1);
    wait_done("done_k92", 60);

    issue(162, 1);
    wait_done("done_k162", 60);
    tick();

    issue(163, 2);
    check("busy_on_reject", int'(busy), 0);
    tick();
    check("err_one_cycle", int'(err), 0);
    check("busy_after_reject", int'(busy), 0);
    check("valid_after_reject", int'(weights_valid), 1);

    issue(1, 1);
    repeat (9) tick();
    start = 1'b1; kidx = KW'(5);
    tick();
    start = 1'b0;
    wait_done("done_k1", 60);
    issue(2, 1);
    wait_done("done_k2", 60);
    tick();

    issue(4, 0);
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rom_ena", int'(rom_ena), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(weights_valid), 0);
    check("abort_flat_zero", int'(weights_flat != '0), 0);
    check("abort_done", int'(done), 0);
    repeat (40) tick();

    start2 = 1'b1; kidx2 = KW'(3);
    q2.push_back('{base: 75, start_edge: cyc + 1});
    tick();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 60) begin
      tick();
      n++;
    end
    check("done2_seen", int'(done2), 1);
    repeat (3) tick();

    check("addr_queue_empty", addr_q.size(), 0);
    check("done_queue_empty", q1.size(), 0);
    check("done2_queue_empty", q2.size(), 0);
    check("err_queue_empty", err_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_kernel_loader.md
Name: weight_kernel_loader

Overview:
Sequencer directly downstream of the 5x5 weight ROM (weight_total_5x5_kernel). On a start request it computes the kernel base address and reads 25 consecutive 16-bit weights through the ROM's ena/addr/dout port. It assembles them into a flat 25-tap register bank and presents that bank, held stable, to the 5x5 convolution engine. Bench and RTL share one clock with the ROM's clka.

Parameters:
DATA_WIDTH, 16, weight word width (matches ROM douta)
ADDR_WIDTH, 12, ROM address width (matches ROM addra)
MEM_DEPTH, 4096, ROM depth in words (1 << ADDR_WIDTH)
KIDX_WIDTH, 8, width of kernel index input
ROM_LATENCY, 1, ROM read latency in cycles (1 or 2)

Ports:
clk  in  1  system clock, also drives ROM clka
rst  in  1  synchronous active-high reset
start  in  1  load request, sampled only in IDLE
kernel_idx  in  KIDX_WIDTH  kernel number; base address = kernel_idx*25
rom_ena  out  1  ROM enable (to ena)
rom_addr  out  ADDR_WIDTH  ROM address (to addra)
rom_dout  in  DATA_WIDTH  ROM read data (from douta)
weights_flat  out  25*DATA_WIDTH  tap k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
weights_valid  out  1  level; bank holds a complete kernel
busy  out  1  load in progress
done  out  1  one-cycle pulse when load completes
err  out  1  one-cycle pulse when a start is rejected as out of range

Behaviour:
- Reset (synchronous, rst high at edge): state IDLE; rom_ena=0, rom_addr=0, weights_flat=0, weights_valid=0, busy=0, done=0, err=0; issue/capture counters and latency pipe cleared. rst overrides every other input.
- Reset mid-load: abort immediately. Next cycle all outputs are at reset values. No partial bank is ever flagged valid.
- States: IDLE, ISSUE, DRAIN.
- IDLE, start=1: compute base = kernel_idx*25, full width, no truncation.
  - If base+24 > MEM_DEPTH-1: err=1 for one cycle, stay IDLE, bank and weights_valid unchanged.
  - Otherwise: go to ISSUE, busy=1, weights_valid=0, rom_ena=1, rom_addr=base.
- ISSUE: rom_addr increments by 1 each cycle through base+24 (25 cycles with rom_ena=1). Then go to DRAIN with rom_ena=0 and rom_addr held.
- Capture: a ROM_LATENCY-deep valid/tap-index pipe tracks each issued address. When the pipe output is valid, rom_dout is written to tap idx. Tap k = row k/5, column k%5 (row-major, the ROM layout).
- DRAIN: wait until tap 24 is captured. On that same edge: done=1 (one cycle), weights_valid=1, busy=0, state IDLE.
- Latency: done is visible 25+ROM_LATENCY edges after the edge that sampled start (26 for ROM_LATENCY=1).
- start while busy: ignored, no queueing. start in the done cycle (state IDLE) is accepted.
- weights_flat changes only on tap capture or reset. Once valid, it stays constant until the next accepted start.
- rom_addr never wraps. The range check guarantees base+24 <= MEM_DEPTH-1.

Decomposition:
- Shared conv package/include holds: KERNEL_DIM=5, KERNEL_TAPS=25, DATA_WIDTH, ADDR_WIDTH, and the loader state encoding (IDLE/ISSUE/DRAIN).
- One sub-module: rom_read_pipe, a ROM_LATENCY-deep shift register carrying {valid, tap_idx[4:0]} that aligns captures with rom_dout.

Test Plan:
- Bench ROM model: mem[i]=i, ROM_LATENCY=1. Start with kernel_idx=0 -> rom_addr 0..24 on 25 consecutive cycles; done exactly 26 edges after start; tap k = k; weights_valid=1.
- kernel_idx=92 -> base 2300; tap0=2300, tap1=2301, tap24=2324.
- kernel_idx=162 -> base 4050, tap24=4074, valid. kernel_idx=163 (last address 4099 > 4095) -> err pulse one cycle, busy never rises, previous bank and weights_valid retained.
- Start kernel_idx=1; pulse start with kernel_idx=5 at cycle 10 -> ignored, bank = 25..49. Then start kernel_idx=2 in the done cycle -> accepted, bank = 50..74.
- Start kernel_idx=4; rst=1 at cycle 12 -> next cycle rom_ena=0, busy=0, weights_valid=0, weights_flat=0, done never pulses.
- ROM_LATENCY=2 build, kernel_idx=3 -> done 27 edges after start, tap k = 75+k.
